// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: op codes, flag bit positions,
// FSM state encoding and the captured-response record.
package alu_pkg;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_OR  = 2'b11;

   localparam int FLAG_Z = 3;
   localparam int FLAG_N = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] EXEC = 2'b01;
   localparam logic [1:0] RESP = 2'b10;

   typedef struct packed {
      logic [7:0] result;
      logic [3:0] flags;
   } alu_rsp_t;

endpackage

// File: rtl/alu_arbiter_rr_picker.sv
// Stateless round-robin picker: first asserted request at or after rr_ptr,
// wrapping modulo NREQ, returned as one-hot grant plus index.
module rr_picker #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req_valid,
   input  logic [IDW-1:0]  rr_ptr,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  grant_idx,
   output logic            grant_vld
);

   // scan outward from rr_ptr; the first hit locks out later candidates
   always_comb begin
      int  idx;
      logic take;
      grant     = '0;
      grant_idx = '0;
      grant_vld = 1'b0;
      idx       = 0;
      take      = 1'b0;
      for (int off = 0; off < NREQ; off++) begin
         idx        = (int'(rr_ptr) + off) % NREQ;
         take       = req_valid[idx] & ~grant_vld;
         grant[idx] = grant[idx] | take;
         grant_idx  = take ? IDW'(idx) : grant_idx;
         grant_vld  = grant_vld | take;
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 8-bit ALU among NREQ requesters, one op in flight.
// Optional build macro ALU_ARB_STICKY_V_EN adds per-requester sticky overflow bits.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter  int NREQ = 4,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst,
`ifdef ALU_ARB_STICKY_V_EN
   input  logic [NREQ-1:0]   sticky_clr,
   output logic [NREQ-1:0]   sticky_v,
`endif
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*8-1:0] req_a,
   input  logic [NREQ*8-1:0] req_b,
   input  logic [NREQ*2-1:0] req_op,
   output logic [7:0]        alu_a,
   output logic [7:0]        alu_b,
   output logic [1:0]        alu_ctrl,
   input  logic [7:0]        alu_result,
   input  logic [3:0]        alu_flags,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic [7:0]        rsp_result,
   output logic [3:0]        rsp_flags
);

   logic [1:0]      state_q, state_d;
   logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [IDW-1:0]  rsp_id_q, rsp_id_d;
   alu_rsp_t        rsp_q, rsp_d;
   logic [7:0]      alu_a_q, alu_a_d;
   logic [7:0]      alu_b_q, alu_b_d;
   logic [1:0]      alu_ctrl_q, alu_ctrl_d;

   logic [NREQ-1:0] pick_grant;
   logic [IDW-1:0]  pick_idx;
   logic            pick_vld;
   logic            rsp_hs;

   rr_picker #(.NREQ(NREQ), .IDW(IDW)) u_picker (
      .req_valid (req_valid),
      .rr_ptr    (rr_ptr_q),
      .grant     (pick_grant),
      .grant_idx (pick_idx),
      .grant_vld (pick_vld)
   );

   assign rsp_hs = (state_q == RESP) && rsp_ready;

   // next-state, grant and operand/response capture
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_d       = rsp_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_ctrl_d  = alu_ctrl_q;
      req_ready   = '0;
      case (state_q)
         IDLE: begin
            // gated by rst so nothing is accepted while reset is held
            if (pick_vld && !rst) begin
               req_ready  = pick_grant;
               alu_a_d    = req_a[8*pick_idx +: 8];
               alu_b_d    = req_b[8*pick_idx +: 8];
               alu_ctrl_d = req_op[2*pick_idx +: 2];
               rsp_id_d   = pick_idx;
               state_d    = EXEC;
            end else begin
               req_ready  = '0;
            end
         end
         EXEC: begin
            rsp_d       = '{result: alu_result, flags: alu_flags};
            rsp_valid_d = 1'b1;
            state_d     = RESP;
         end
         RESP: begin
            if (rsp_hs) begin
               rsp_valid_d = 1'b0;
               rr_ptr_d    = (rsp_id_q == IDW'(NREQ - 1)) ? '0 : rsp_id_q + IDW'(1);
               state_d     = IDLE;
            end else begin
               rsp_valid_d = 1'b1;
            end
         end
         default: begin
            state_d     = IDLE;
            rsp_valid_d = 1'b0;
         end
      endcase
   end

   // state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_q       <= '{result: 8'h00, flags: 4'h0};
         alu_a_q     <= 8'h00;
         alu_b_q     <= 8'h00;
         alu_ctrl_q  <= ALU_ADD;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_q       <= rsp_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_ctrl_q  <= alu_ctrl_d;
      end
   end

   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_ctrl   = alu_ctrl_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_result = rsp_q.result;
   assign rsp_flags  = rsp_q.flags;

`ifdef ALU_ARB_STICKY_V_EN
   logic [NREQ-1:0] sticky_q, sticky_d, sticky_set;

   // overflow seen on a completed handshake; clear has priority over set
   always_comb begin
      sticky_set = (rsp_hs && rsp_q.flags[FLAG_V]) ? (NREQ'(1) << rsp_id_q) : '0;
      sticky_d   = (sticky_q | sticky_set) & ~sticky_clr;
   end

   // sticky overflow register
   always_ff @(posedge clk) begin
      if (rst) begin
         sticky_q <= '0;
      end else begin
         sticky_q <= sticky_d;
      end
   end

   assign sticky_v = sticky_q;
`endif

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one 8-bit ALU instance (ops ADD/SUB/AND/OR; flags Z, N, C, V) among NREQ requesters.
- Round-robin arbitration over per-requester valid/ready request channels.
- Drives the ALU operands and control from registered values, captures result and flags, and returns them on a single shared response channel tagged with the requester ID.
- Sits between the instruction-issue logic and the ALU datapath.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, $clog2(NREQ), requester ID width (derived, not overridden)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous reset, active-high
req_valid  input  NREQ  per-requester request valid
req_ready  output  NREQ  per-requester accept; one-hot or zero
req_a  input  NREQ*8  operand A, requester i at [8i+7:8i]
req_b  input  NREQ*8  operand B, same packing
req_op  input  NREQ*2  ALU control, requester i at [2i+1:2i]; 00 ADD, 01 SUB, 10 AND, 11 OR
alu_a  output  8  operand A to ALU
alu_b  output  8  operand B to ALU
alu_ctrl  output  2  ALU control
alu_result  input  8  ALU result (combinational from alu_a/alu_b/alu_ctrl)
alu_flags  input  4  {Z,N,C,V} from ALU
rsp_valid  output  1  response valid
rsp_ready  input  1  response accept
rsp_id  output  IDW  requester that owns the response
rsp_result  output  8  captured result
rsp_flags  output  4  captured {Z,N,C,V}

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: state=IDLE, rr_ptr=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flags=0, alu_a/alu_b/alu_ctrl=0 (all registered), req_ready=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant the first asserted req_valid at or after rr_ptr, wrapping modulo NREQ.
  - req_ready[grant]=1 combinationally that cycle.
  - Latch that requester's a/b/op into alu_a/alu_b/alu_ctrl and its index into rsp_id, then go to EXEC.
  - With no valid request, stay in IDLE with req_ready=0.
- EXEC: ALU settles on the registered operands. At the clock edge, capture rsp_result<=alu_result and rsp_flags<=alu_flags, set rsp_valid<=1, and go to RESP.
- RESP:
  - Hold rsp_* stable while rsp_valid=1 && rsp_ready=0.
  - On handshake, set rsp_valid<=0, rr_ptr<=(rsp_id+1) mod NREQ, and go to IDLE.
  - No new grant is made in RESP.
- Timing:
  - Latency is accept at cycle t, rsp_valid at t+2.
  - Minimum issue interval is 3 cycles.
  - Exactly one operation is in flight.
- Flags: passed through unmodified from the ALU, including C=0 for AND/OR. The arbiter does no arithmetic.
- Arbitration rules:
  - req_valid must not depend on req_ready.
  - A requester that drops req_valid before grant loses nothing.
  - Simultaneous requests are resolved purely by rr_ptr.
  - Under continuous all-valid load, grants rotate 0,1,2,3,0...
- Reset mid-operation: the in-flight op is discarded and not replayed, rsp_valid drops the next cycle, and rr_ptr returns to 0.
- alu_a/alu_b/alu_ctrl hold their last values outside EXEC.

Optional Feature:
ALU_ARB_STICKY_V_EN:
- When defined, adds output sticky_v (NREQ bits) and input sticky_clr (NREQ bits).
- sticky_v[i] is set when a response for requester i completes its handshake with V=1.
- sticky_clr[i] clears sticky_v[i]; clear wins over a simultaneous set.
- Resets to 0.
- When undefined, neither port nor its logic exists.

Decomposition:
- Shared package alu_pkg:
  - op localparams ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10, ALU_OR=2'b11
  - flag indices FLAG_Z=3, FLAG_N=2, FLAG_C=1, FLAG_V=0
  - FSM state encoding IDLE/EXEC/RESP
- Sub-module rr_picker: combinational round-robin pick from (req_valid, rr_ptr) to one-hot grant plus index; no state.

Test Plan:
- Single request: req0 ADD a=8'h7F b=8'h01 -> req_ready[0] same cycle; rsp_valid 2 cycles later; rsp_id=0, rsp_result=8'h80, N=1, Z=0.
- SUB equal operands: req2 SUB a=8'h05 b=8'h05 -> rsp_result=8'h00, Z=1, C=1, rsp_id=2.
- AND zero result: req1 AND a=8'hF0 b=8'h0F -> rsp_result=8'h00, Z=1, C=0.
- All four requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0 with one grant every 3 cycles.
- Backpressure: rsp_ready=0 for 5 cycles -> rsp_* stable, no req_ready asserted; release -> handshake, next grant goes to rsp_id+1.
- Reset asserted in EXEC -> next cycle state IDLE, rsp_valid=0; pending requester is regranted only after reasserting req_valid, with rr_ptr=0.
